// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern transmitter and the detectors it feeds:
// FSM state encoding, reference patterns and the serial line idle level.
package seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam logic [3:0] PAT_0001   = 4'b0001;
    localparam logic [3:0] PAT_0101   = 4'b0101;
    localparam logic       IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/seq_pattern_gen_piso_shifter.sv
// Parallel-in serial-out shifter, MSB first. Keeps a captured copy of the pattern
// so every repetition can restart from the original bits. The serial bit is a
// register that falls back to the idle level whenever no command is given.
module piso_shifter
    import seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] pattern_i,
    input  logic             reload_i,
    input  logic             shift_i,
    output logic             bit_o
);

    logic [WIDTH-1:0] copy_q, copy_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic             bit_q, bit_d;

    // Pick the next serial bit; sreg holds the bits still to be sent, MSB aligned
    always_comb begin
        copy_d = copy_q;
        sreg_d = sreg_q;
        bit_d  = IDLE_LEVEL;
        if (load_i) begin
            copy_d = pattern_i;
            sreg_d = {pattern_i[WIDTH-2:0], 1'b0};
            bit_d  = pattern_i[WIDTH-1];
        end else if (reload_i) begin
            sreg_d = {copy_q[WIDTH-2:0], 1'b0};
            bit_d  = copy_q[WIDTH-1];
        end else if (shift_i) begin
            sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
            bit_d  = sreg_q[WIDTH-1];
        end
    end

    // Shifter registers; reset leaves the line at its idle level
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            copy_q <= '0;
            sreg_q <= '0;
            bit_q  <= IDLE_LEVEL;
        end else begin
            copy_q <= copy_d;
            sreg_q <= sreg_d;
            bit_q  <= bit_d;
        end
    end

    assign bit_o = bit_q;

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial bit-pattern transmitter: sends a captured WIDTH-bit pattern MSB first,
// repeat_n times, with GAP idle-high bits between repetitions, then pulses done.
module seq_pattern_gen
    import seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8,
    parameter int GAP   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_n,
    output logic             ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             last_bit,
    output logic             done
);

    localparam int                 BIT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int                 GAP_W    = 4;
    localparam logic [BIT_W-1:0]   LAST_IDX = BIT_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0]   GAP_LAST = (GAP > 0) ? GAP_W'(GAP - 1) : '0;
    localparam logic [CNT_W-1:0]   ONE_REP  = CNT_W'(1);

    state_e           state_q, state_d;
    logic [BIT_W-1:0] bitcnt_q, bitcnt_d;
    logic [GAP_W-1:0] gapcnt_q, gapcnt_d;
    logic [CNT_W-1:0] reps_q, reps_d;

    logic ready_q, ready_d;
    logic valid_q, valid_d;
    logic last_q, last_d;
    logic done_q, done_d;

    logic loadCmd, reloadCmd, shiftCmd;
    logic atLastBit;
    logic shifterBit;

    assign atLastBit = (bitcnt_q == LAST_IDX);

    // State and counter registers; reset abandons any transfer in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            bitcnt_q <= '0;
            gapcnt_q <= '0;
            reps_q   <= '0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            gapcnt_q <= gapcnt_d;
            reps_q   <= reps_d;
        end
    end

    // Next state: walk the bits, count down repetitions, insert gaps between them
    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        gapcnt_d = gapcnt_q;
        reps_d   = reps_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    reps_d   = repeat_n;
                    bitcnt_d = '0;
                    gapcnt_d = '0;
                    state_d  = (repeat_n == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (atLastBit) begin
                    if (reps_q != '0) begin
                        reps_d = reps_q - ONE_REP;
                    end
                    bitcnt_d = '0;
                    gapcnt_d = '0;
                    if (reps_q <= ONE_REP) begin
                        state_d = S_DONE;
                    end else if (GAP > 0) begin
                        state_d = S_GAP;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end else begin
                    bitcnt_d = bitcnt_q + BIT_W'(1);
                end
            end
            S_GAP: begin
                if (gapcnt_q == GAP_LAST) begin
                    gapcnt_d = '0;
                    state_d  = S_SHIFT;
                end else begin
                    gapcnt_d = gapcnt_q + GAP_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs for the coming cycle, derived from where the FSM is heading
    always_comb begin
        loadCmd   = (state_q == S_IDLE) && start && (repeat_n != '0);
        shiftCmd  = (state_q == S_SHIFT) && !atLastBit;
        reloadCmd = (state_d == S_SHIFT) &&
                    ((state_q == S_GAP) || ((state_q == S_SHIFT) && atLastBit));
        ready_d   = (state_d == S_IDLE);
        valid_d   = (state_d == S_SHIFT);
        last_d    = (state_d == S_SHIFT) && (bitcnt_d == LAST_IDX);
        done_d    = (state_d == S_DONE);
    end

    // Output registers so nothing downstream sees combinational glitches
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            ready_q <= ready_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    piso_shifter #(
        .WIDTH (WIDTH)
    ) u_shifter (
        .clk       (clk),
        .reset     (reset),
        .load_i    (loadCmd),
        .pattern_i (pattern),
        .reload_i  (reloadCmd),
        .shift_i   (shiftCmd),
        .bit_o     (shifterBit)
    );

    assign ready      = ready_q;
    assign dout       = shifterBit;
    assign dout_valid = valid_q;
    assign last_bit   = last_q;
    assign done       = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Bench for seq_pattern_gen: two instances (GAP=2 and GAP=0) checked every cycle
// against an arithmetic model of the output stream, plus directed literal checks.
module tb_seq_pattern_gen;
    import seq_pkg::*;

    localparam int W    = 4;
    localparam int GAPA = 2;
    localparam int GAPB = 0;

    typedef struct packed {
        logic ready;
        logic dout;
        logic valid;
        logic last;
        logic done;
    } exp_t;

    logic       clk;
    logic       rstN;
    logic       startA, startB;
    logic [3:0] patternA, patternB;
    logic [7:0] repA, repB;
    logic       readyA, doutA, validA, lastA, doneA;
    logic       readyB, doutB, validB, lastB, doneB;

    int checks = 0;
    int errors = 0;
    int edgeCnt = 0;

    logic       actA, actB;
    int         accA, accB, nA, nB;
    logic [3:0] patA, patB;

    seq_pattern_gen #(.WIDTH(W), .CNT_W(8), .GAP(GAPA)) dutA (
        .clk        (clk),
        .reset      (rstN),
        .start      (startA),
        .pattern    (patternA),
        .repeat_n   (repA),
        .ready      (readyA),
        .dout       (doutA),
        .dout_valid (validA),
        .last_bit   (lastA),
        .done       (doneA)
    );

    seq_pattern_gen #(.WIDTH(W), .CNT_W(8), .GAP(GAPB)) dutB (
        .clk        (clk),
        .reset      (rstN),
        .start      (startB),
        .pattern    (patternB),
        .repeat_n   (repB),
        .ready      (readyB),
        .dout       (doutB),
        .dout_valid (validB),
        .last_bit   (lastB),
        .done       (doneB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs k cycles after the accepting edge, from the stream layout
    function automatic exp_t expOf(input logic act, input int acc, input logic [3:0] pat,
                                   input int n, input int gap, input int now);
        exp_t e;
        int   k;
        int   total;
        int   pos;
        e.ready = 1'b1;
        e.dout  = 1'b1;
        e.valid = 1'b0;
        e.last  = 1'b0;
        e.done  = 1'b0;
        if (act) begin
            k     = now - acc;
            total = n * W + ((n > 0) ? (n - 1) * gap : 0);
            if (k < total) begin
                pos     = k % (W + gap);
                e.ready = 1'b0;
                if (pos < W) begin
                    e.dout  = pat[W-1-pos];
                    e.valid = 1'b1;
                    e.last  = (pos == W - 1);
                end
            end else if (k == total) begin
                e.ready = 1'b0;
                e.done  = 1'b1;
            end
        end
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // Free-running edge index used to time each transfer
    always @(posedge clk) edgeCnt <= edgeCnt + 1;

    // Model: record accepted transfers; ready comes from the model's own view of the cycle
    always @(posedge clk or negedge rstN) begin : model
        exp_t pa, pb;
        if (!rstN) begin
            actA <= 1'b0;
            actB <= 1'b0;
        end else begin
            pa = expOf(actA, accA, patA, nA, GAPA, edgeCnt);
            pb = expOf(actB, accB, patB, nB, GAPB, edgeCnt);
            if (startA && pa.ready) begin
                actA <= 1'b1;
                accA <= edgeCnt + 1;
                patA <= patternA;
                nA   <= int'(repA);
            end
            if (startB && pb.ready) begin
                actB <= 1'b1;
                accB <= edgeCnt + 1;
                patB <= patternB;
                nB   <= int'(repB);
            end
        end
    end

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin : compare
        exp_t ea, eb;
        ea = expOf(actA, accA, patA, nA, GAPA, edgeCnt);
        eb = expOf(actB, accB, patB, nB, GAPB, edgeCnt);
        checkOutput("A.ready", 16'(readyA), 16'(ea.ready));
        checkOutput("A.dout",  16'(doutA),  16'(ea.dout));
        checkOutput("A.valid", 16'(validA), 16'(ea.valid));
        checkOutput("A.last",  16'(lastA),  16'(ea.last));
        checkOutput("A.done",  16'(doneA),  16'(ea.done));
        checkOutput("B.ready", 16'(readyB), 16'(eb.ready));
        checkOutput("B.dout",  16'(doutB),  16'(eb.dout));
        checkOutput("B.valid", 16'(validB), 16'(eb.valid));
        checkOutput("B.last",  16'(lastB),  16'(eb.last));
        checkOutput("B.done",  16'(doneB),  16'(eb.done));
    end

    // Called at a negedge: request a transfer, then sample len cycles of the stream
    task automatic applyStimulus(input bit selB, input logic [3:0] pat, input logic [7:0] n,
                                 input int len, input int midStart,
                                 output logic [15:0] stream, output int vCnt, output int lCnt);
        stream = '0;
        vCnt   = 0;
        lCnt   = 0;
        if (selB) begin startB = 1'b1; patternB = pat; repB = n; end
        else      begin startA = 1'b1; patternA = pat; repA = n; end
        @(negedge clk);
        for (int i = 0; i < len; i++) begin
            if (selB) begin
                startB   = (i == midStart);
                patternB = (i == midStart) ? 4'hF : pat;
                repB     = (i == midStart) ? 8'd7 : n;
                stream   = {stream[14:0], doutB};
                vCnt    += int'(validB);
                lCnt    += int'(lastB);
            end else begin
                startA   = (i == midStart);
                patternA = (i == midStart) ? 4'hF : pat;
                repA     = (i == midStart) ? 8'd7 : n;
                stream   = {stream[14:0], doutA};
                vCnt    += int'(validA);
                lCnt    += int'(lastA);
            end
            @(negedge clk);
        end
        startA = 1'b0;
        startB = 1'b0;
    endtask

    initial begin : stim
        logic [15:0] s;
        int          v;
        int          l;
        rstN     = 1'b0;
        startA   = 1'b0;
        startB   = 1'b0;
        patternA = '0;
        patternB = '0;
        repA     = '0;
        repB     = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        checkOutput("rst.ready", 16'(readyA), 16'd1);
        checkOutput("rst.dout",  16'(doutA),  16'd1);
        checkOutput("rst.valid", 16'(validA), 16'd0);
        checkOutput("rst.done",  16'(doneA),  16'd0);
        repeat (3) @(negedge clk);
        checkOutput("idle.ready", 16'(readyA), 16'd1);
        checkOutput("idle.valid", 16'(validA), 16'd0);

        applyStimulus(1'b0, PAT_0001, 8'd1, 4, -1, s, v, l);
        checkOutput("p0001.stream", s, 16'h0001);
        checkOutput("p0001.valid",  16'(v), 16'd4);
        checkOutput("p0001.last",   16'(l), 16'd1);
        checkOutput("p0001.done",   16'(doneA), 16'd1);
        @(negedge clk);
        checkOutput("p0001.ready",  16'(readyA), 16'd1);

        applyStimulus(1'b0, PAT_0101, 8'd3, 16, 5, s, v, l);
        checkOutput("p0101x3.stream", s, 16'b0101110101110101);
        checkOutput("p0101x3.valid",  16'(v), 16'd12);
        checkOutput("p0101x3.last",   16'(l), 16'd3);
        checkOutput("p0101x3.done",   16'(doneA), 16'd1);
        @(negedge clk);
        checkOutput("p0101x3.ready",  16'(readyA), 16'd1);

        applyStimulus(1'b1, PAT_0001, 8'd2, 8, -1, s, v, l);
        checkOutput("gap0.stream", s, 16'b00010001);
        checkOutput("gap0.valid",  16'(v), 16'd8);
        checkOutput("gap0.last",   16'(l), 16'd2);
        checkOutput("gap0.done",   16'(doneB), 16'd1);
        @(negedge clk);
        checkOutput("gap0.ready",  16'(readyB), 16'd1);

        applyStimulus(1'b0, PAT_0101, 8'd0, 0, -1, s, v, l);
        checkOutput("rep0.done",  16'(doneA),  16'd1);
        checkOutput("rep0.valid", 16'(validA), 16'd0);
        @(negedge clk);
        checkOutput("rep0.ready", 16'(readyA), 16'd1);

        startA   = 1'b1;
        patternA = PAT_0001;
        repA     = 8'd1;
        @(negedge clk);
        startA = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("abort.bit3", 16'(doutA), 16'd0);
        #1 rstN = 1'b0;
        #1;
        checkOutput("abort.dout",  16'(doutA),  16'd1);
        checkOutput("abort.valid", 16'(validA), 16'd0);
        checkOutput("abort.ready", 16'(readyA), 16'd1);
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("abort.nodone", 16'(doneA), 16'd0);
        end
        applyStimulus(1'b0, PAT_0001, 8'd1, 4, -1, s, v, l);
        checkOutput("fresh.stream", s, 16'h0001);
        checkOutput("fresh.done",   16'(doneA), 16'd1);
        @(negedge clk);

        for (int i = 0; i < 1500; i++) begin
            startA   = ($urandom_range(0, 3) == 0);
            patternA = 4'($urandom);
            repA     = 8'($urandom_range(0, 4));
            startB   = ($urandom_range(0, 3) == 0);
            patternB = 4'($urandom);
            repB     = 8'($urandom_range(0, 4));
            @(negedge clk);
        end
        startA = 1'b0;
        startB = 1'b0;
        repeat (40) @(negedge clk);
        checkOutput("end.readyA", 16'(readyA), 16'd1);
        checkOutput("end.readyB", 16'(readyB), 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_pattern_gen.md
# seq_pattern_gen

Serial bit-pattern transmitter: accepts a WIDTH-bit pattern and a repeat count, then drives it MSB-first onto a single-bit serial line, with GAP idle-high bits between repetitions. It is the stimulus/transmit end of the serial bit line consumed by the team's Mealy sequence detectors (0001/0101 class). It sits upstream of the detector's din and is also used as a bench driver.

## Interface
- WIDTH, 4: pattern length in bits, legal 2..16
- CNT_W, 8: repeat-count width
- GAP, 2: idle-high bits inserted between repetitions, legal 0..15
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  request; accepted only when sampled high with ready=1
- pattern  in  WIDTH  pattern to send, captured at accept
- repeat_n  in  CNT_W  number of repetitions, captured at accept
- ready  out  1  idle, can accept start
- dout  out  1  serial data; idle level 1
- dout_valid  out  1  dout carries a pattern bit this cycle
- last_bit  out  1  dout is the final bit of a repetition
- done  out  1  one-cycle pulse, transfer complete

## Operation
- All outputs registered. Reset values: ready=1, dout=1, dout_valid=0, last_bit=0, done=0; state IDLE, counters 0.
- FSM states: IDLE, SHIFT, GAP, DONE.
- IDLE: ready=1, dout=1. On start=1: capture pattern and repeat_n, clear bit counter. If repeat_n=0 go to DONE, else go to SHIFT.
- SHIFT: dout=pattern[WIDTH-1-bitcnt], dout_valid=1; bitcnt increments each cycle. On bitcnt=WIDTH-1: last_bit=1, decrement remaining reps. Remaining=0 → DONE. Otherwise GAP (GAP>0) or SHIFT with bitcnt=0 (GAP=0, no bubble).
- GAP: dout=1, dout_valid=0, for exactly GAP cycles, then SHIFT with bitcnt=0.
- DONE: done=1, ready=0, dout=1, for one cycle, then IDLE.
- start when ready=0 is ignored, with no queuing. pattern/repeat_n changes after accept have no effect.
- Reset asserted mid-transfer: outputs go to reset values immediately, asynchronously. The transfer is abandoned and done is not pulsed.
- Counters: bitcnt is ceil(log2(WIDTH)) bits; reps is CNT_W bits and never wraps (decrement only when nonzero).

## Timing
- Accept at edge E0. First bit is visible after E0; bit i is visible after E0+i. ready=0 from E0.
- Stream length for n≥1: n·WIDTH + (n−1)·GAP cycles. done is high in the following cycle. ready=1 the cycle after done, so the earliest next accept is at that cycle's edge.
- repeat_n=0: done is high in the cycle after E0, with no dout_valid cycles.
- last_bit is asserted together with dout_valid on every repetition's final bit, and never during GAP.

## Structure
- Shared package seq_pkg:
  - state encoding constants S_IDLE, S_SHIFT, S_GAP, S_DONE
  - pattern constants PAT_0001=4'b0001, PAT_0101=4'b0101
  - IDLE_LEVEL=1'b1
- One natural sub-module: piso_shifter. It takes a WIDTH parameter, does parallel load and MSB-first shift, and reloads from a captured copy for each repetition. The FSM and counters stay in the top.

## Test plan
- Reset: hold reset=0 across edges, then release → ready=1, dout=1, dout_valid=0, done=0, and idle persists with start=0.
- pattern=4'b0001, repeat_n=1 → dout 0,0,0,1 on 4 consecutive cycles with dout_valid=1, last_bit on the 4th, done on cycle 5, ready on cycle 6.
- pattern=4'b0101, repeat_n=3, GAP=2 → 0101 11 0101 11 0101 (16 cycles), dout_valid low on the gap bits, last_bit ×3. Feeding the detector gives y=1 exactly 3 times.
- GAP=0, pattern=4'b0001, repeat_n=2 → contiguous 00010001, dout_valid high for 8 cycles; the detector fires twice.
- repeat_n=0 → no dout_valid; done pulses in the cycle after accept; ready returns the cycle after.
- start pulsed mid-stream is ignored (stream unchanged). reset=0 at the 3rd bit makes dout=1 and dout_valid=0 immediately, with no done pulse. A fresh start after release sends the full pattern.
